dp_ram: RTL and testbench
=========================

DP_RAM -- requirements
Module: dp_ram

Interface
REQ-001 The module SHALL have parameter ADDRWIDTH, default 8, giving the address width; depth = 2^ADDRWIDTH words.
REQ-002 The module SHALL have parameter DATAWIDTH, default 8, giving the word width.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port address_a, input, ADDRWIDTH bits: port A address.
REQ-006 The module SHALL have port data_a, input, DATAWIDTH bits: port A write data.
REQ-007 The module SHALL have port wren_a, input, 1 bit: port A write enable.
REQ-008 The module SHALL have port q_a, output, DATAWIDTH bits: port A registered read data.
REQ-009 The module SHALL have port address_b, input, ADDRWIDTH bits: port B address.
REQ-010 The module SHALL have port data_b, input, DATAWIDTH bits: port B write data.
REQ-011 The module SHALL have port wren_b, input, 1 bit: port B write enable.
REQ-012 The module SHALL have port q_b, output, DATAWIDTH bits: port B registered read data.

Function
REQ-013 Both ports SHALL be fully independent read/write ports on one shared storage array.
REQ-014 Each port SHALL read every cycle; q_x SHALL show mem[address_x] sampled at edge N, valid after edge N (latency 1).
REQ-015 When wren_x=1 at edge N, mem[address_x] SHALL be loaded with data_x at edge N.
REQ-016 A same-port read during write SHALL be read-first: q_x returns the old contents; the new data is visible from the next read.
REQ-017 A cross-port read of an address that the other port writes in the same cycle SHALL return the old contents.
REQ-018 When both ports write the same address in the same cycle, port A's data SHALL be stored and port B's write discarded.
REQ-019 Writes to different addresses in the same cycle SHALL both complete.
REQ-020 Addresses SHALL cover the full 2^ADDRWIDTH range with no wrap or aliasing; X/Z inputs are out of scope.
REQ-021 Memory contents at power-up SHALL be all zeros (initial content, synthesizable as RAM init).

Reset
REQ-022 While reset=1 at an edge, q_a and q_b SHALL be loaded with 0.
REQ-023 While reset=1 at an edge, writes from both ports SHALL be suppressed.
REQ-024 Reset SHALL NOT clear memory contents.
REQ-025 Normal reads SHALL resume at the first edge after reset deasserts.

Configuration
REQ-026 With macro DP_RAM_OUTREG_EN defined, each port SHALL add a second output register stage, giving read latency 2; this stage is also cleared by reset.
REQ-027 Without DP_RAM_OUTREG_EN, read latency SHALL be 1 as in REQ-014.
REQ-028 Write behaviour and collision rules SHALL be identical with and without DP_RAM_OUTREG_EN.

Structure
REQ-029 Package dp_ram_pkg SHALL hold the default ADDRWIDTH/DATAWIDTH constants and the read-latency constant derived from DP_RAM_OUTREG_EN.
REQ-030 The module SHALL have a single storage array with per-port read registers.
REQ-031 The output pipeline SHALL be a sub-module dp_ram_outreg, instantiated once per port.

Verification
REQ-032 Write 0x5A to address 0x10 via A, then read 0x10 via B the next cycle -> q_b=0x5A one cycle later (two with DP_RAM_OUTREG_EN).
REQ-033 mem[0x20]=0x11; A writes 0x22 to 0x20 while reading 0x20 -> q_a=0x11 that cycle, and 0x22 on the following read.
REQ-034 A writes 0xAA and B writes 0xBB to 0x30 in the same cycle -> both ports subsequently read 0xAA.
REQ-035 Assert reset with wren_a=1, address 0x40, data 0xFF -> q_a=q_b=0 and mem[0x40] unchanged (0x00).
REQ-036 After reset, fill via B at 0x00..0xFF with data=address, then read back via A -> each q_a equals its address, including 0xFF.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared constants for the dual-port RAM: default geometry and the read latency,
// which becomes 2 when DP_RAM_OUTREG_EN is defined.
package dp_ram_pkg;

  localparam int DEF_ADDRWIDTH = 8;
  localparam int DEF_DATAWIDTH = 8;

`ifdef DP_RAM_OUTREG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/dp_ram_if.sv
// Bus bundle for both ports of dp_ram; the master drives address/data/enable,
// the slave (the RAM) returns the registered read data.
interface dp_ram_if
  import dp_ram_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DATAWIDTH = DEF_DATAWIDTH
);

  logic [ADDRWIDTH-1:0] address_a;
  logic [DATAWIDTH-1:0] data_a;
  logic                 wren_a;
  logic [DATAWIDTH-1:0] q_a;

  logic [ADDRWIDTH-1:0] address_b;
  logic [DATAWIDTH-1:0] data_b;
  logic                 wren_b;
  logic [DATAWIDTH-1:0] q_b;

  modport master (
    output address_a, data_a, wren_a,
    output address_b, data_b, wren_b,
    input  q_a, q_b
  );

  modport slave (
    input  address_a, data_a, wren_a,
    input  address_b, data_b, wren_b,
    output q_a, q_b
  );

endinterface

// File: rtl/dp_ram_outreg.sv
// Per-port read pipeline: the read register, plus a second register stage when
// DP_RAM_OUTREG_EN is defined. Both stages clear on reset.
module dp_ram_outreg
  import dp_ram_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [DATAWIDTH-1:0] i_d,
  output logic [DATAWIDTH-1:0] o_q
);

  logic [DATAWIDTH-1:0] r_q_p1;

  // stage 1: read register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_q_p1 <= '0;
    else         r_q_p1 <= i_d;
  end

`ifdef DP_RAM_OUTREG_EN
  logic [DATAWIDTH-1:0] r_q_p2;

  // stage 2: optional output register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_q_p2 <= '0;
    else         r_q_p2 <= r_q_p1;
  end

  assign o_q = r_q_p2;
`else
  assign o_q = r_q_p1;
`endif

endmodule

// File: rtl/dp_ram.sv
// True dual-port RAM, read-first on both ports, port A wins same-address write
// collisions. Read latency 1, or 2 with DP_RAM_OUTREG_EN defined.
module dp_ram
  import dp_ram_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic   clock,
  input  logic   reset,
  dp_ram_if.slave bus
);

  localparam int DEPTH = 1 << ADDRWIDTH;

  // Zero power-up contents; reset deliberately leaves the array alone.
  logic [DATAWIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  logic                 w_wr_a;
  logic                 w_wr_b;
  logic [DATAWIDTH-1:0] w_rd_a;
  logic [DATAWIDTH-1:0] w_rd_b;

  // B is dropped when A targets the same word in the same cycle.
  assign w_wr_a = bus.wren_a && !reset;
  assign w_wr_b = bus.wren_b && !reset &&
                  !(bus.wren_a && (bus.address_a == bus.address_b));

  always_ff @(posedge clock) begin
    if (w_wr_a) r_mem[bus.address_a] <= bus.data_a;
    if (w_wr_b) r_mem[bus.address_b] <= bus.data_b;
  end

  assign w_rd_a = r_mem[bus.address_a];
  assign w_rd_b = r_mem[bus.address_b];

  dp_ram_outreg #(.DATAWIDTH(DATAWIDTH)) u_outreg_a (
    .i_clock (clock),
    .i_reset (reset),
    .i_d     (w_rd_a),
    .o_q     (bus.q_a)
  );

  dp_ram_outreg #(.DATAWIDTH(DATAWIDTH)) u_outreg_b (
    .i_clock (clock),
    .i_reset (reset),
    .i_d     (w_rd_b),
    .o_q     (bus.q_b)
  );

endmodule

// File: tb/tb_dp_ram.sv
// Scoreboard bench for dp_ram: expected read data is queued as each cycle is
// driven and popped once the read latency has elapsed.
module tb_dp_ram;
  import dp_ram_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dp_ram_if #(.ADDRWIDTH(8), .DATAWIDTH(8)) bus ();

  dp_ram #(.ADDRWIDTH(8), .DATAWIDTH(8)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [256];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive one clock cycle, predict the read data, then compare whatever is due.
  task automatic cyc(input bit rst,
                     input bit wa, input logic [7:0] aa, input logic [7:0] da,
                     input bit wb, input logic [7:0] ab, input logic [7:0] db,
                     input string tag);
    exp_t e;
    reset         = rst;
    bus.wren_a    = wa;
    bus.address_a = aa;
    bus.data_a    = da;
    bus.wren_b    = wb;
    bus.address_b = ab;
    bus.data_b    = db;
    e.a   = rst ? 8'h00 : mem_m[aa];
    e.b   = rst ? 8'h00 : mem_m[ab];
    e.tag = tag;
    sb.push_back(e);
    if (rst) begin
      foreach (sb[i]) begin
        sb[i].a = 8'h00;
        sb[i].b = 8'h00;
      end
    end else begin
      if (wb && !(wa && (aa == ab))) mem_m[ab] = db;
      if (wa) mem_m[aa] = da;
    end
    @(posedge clock);
    #1;
    if (sb.size() >= RD_LATENCY) begin
      e = sb.pop_front();
      check_val($sformatf("%s.q_a", e.tag), bus.q_a, e.a);
      check_val($sformatf("%s.q_b", e.tag), bus.q_b, e.b);
    end
  endtask

  initial begin
    logic [7:0] ra, rb, rda, rdb;
    bit         rwa, rwb, rrst;
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    bus.wren_a = 1'b0; bus.address_a = '0; bus.data_a = '0;
    bus.wren_b = 1'b0; bus.address_b = '0; bus.data_b = '0;

    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, "reset");

    // A writes, B reads the word on the following cycle
    cyc(0, 1, 8'h10, 8'h5A, 0, 8'h00, 8'h00, "wr10");
    cyc(0, 0, 8'h00, 8'h00, 0, 8'h10, 8'h00, "rd10");

    // same-port read during write returns old data
    cyc(0, 1, 8'h20, 8'h11, 0, 8'h00, 8'h00, "wr20a");
    cyc(0, 1, 8'h20, 8'h22, 0, 8'h00, 8'h00, "rfirst20");
    cyc(0, 0, 8'h20, 8'h00, 0, 8'h20, 8'h00, "rd20");

    // both ports write one word: A wins
    cyc(0, 1, 8'h30, 8'hAA, 1, 8'h30, 8'hBB, "coll30");
    cyc(0, 0, 8'h30, 8'h00, 0, 8'h30, 8'h00, "rd30");

    // cross-port read during write returns old data
    cyc(0, 1, 8'h50, 8'h77, 0, 8'h50, 8'h00, "xport50");
    cyc(0, 0, 8'h50, 8'h00, 1, 8'h51, 8'h99, "xport51");
    cyc(0, 0, 8'h51, 8'h00, 0, 8'h50, 8'h00, "rd5x");

    // simultaneous writes to different words
    cyc(0, 1, 8'h60, 8'h12, 1, 8'h61, 8'h34, "wr6x");
    cyc(0, 0, 8'h61, 8'h00, 0, 8'h60, 8'h00, "rd6x");

    // writes blocked under reset, array not cleared
    cyc(1, 1, 8'h40, 8'hFF, 1, 8'h41, 8'hEE, "rstwr");
    cyc(0, 0, 8'h40, 8'h00, 0, 8'h41, 8'h00, "rd4x");
    cyc(0, 0, 8'h10, 8'h00, 0, 8'h30, 8'h00, "keep");

    // fill via B with data = address, read back via A
    for (int i = 0; i < 256; i++)
      cyc(0, 0, 8'h00, 8'h00, 1, 8'(i), 8'(i), "fill");
    for (int i = 0; i < 256; i++)
      cyc(0, 0, 8'(i), 8'h00, 0, 8'(255 - i), 8'h00, "rdbk");

    // random traffic on a small window to provoke collisions
    for (int i = 0; i < 300; i++) begin
      rrst = ($urandom_range(0, 31) == 0);
      rwa  = $urandom_range(0, 1) == 1;
      rwb  = $urandom_range(0, 1) == 1;
      ra   = 8'h70 | 8'($urandom_range(0, 7));
      rb   = 8'h70 | 8'($urandom_range(0, 7));
      rda  = 8'($urandom_range(0, 255));
      rdb  = 8'($urandom_range(0, 255));
      cyc(rrst, rwa, ra, rda, rwb, rb, rdb, "rand");
    end

    for (int i = 0; i < RD_LATENCY; i++) cyc(0, 0, 8'h70, 8'h00, 0, 8'h77, 8'h00, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
